// File: rtl/rhd_spi_slot_sequencer.sv
// rhd_spi_slot_sequencer
//
// Frame engine for one RHD-style amplifier SPI port. Walks a slot index through
// 0..NUM_SLOTS-1. For each slot it latches the command word returned by the
// downstream command selector and shifts it out MSB-first on SCLK/MOSI under
// CS_b. In the same slot it captures the 16-bit MISO reply. Each reply is
// presented with its slot index, and frame boundaries are marked with a pulse
// and a completed-frame timestamp.
//
// Ports:
//   dataclk      in   block clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   run          in   1 = start/keep framing, 0 = stop at next frame boundary
//   mosi_cmd     in   command word for the current channel
//   MISO         in   serial reply from the amplifier
//   channel      out  current slot index, to the command selector
//   CS_b         out  active-low chip select
//   SCLK         out  SPI clock, idle low
//   MOSI         out  serial command data
//   miso_word    out  last captured reply
//   word_channel out  slot index of miso_word
//   word_valid   out  one-cycle pulse when miso_word/word_channel update
//   frame_done   out  one-cycle pulse alongside word_valid of the last slot
//   timestamp    out  completed-frame count
//   busy         out  high whenever the engine is not idle
module rhd_spi_slot_sequencer #(
    parameter int unsigned NUM_SLOTS      = 35,
    parameter int unsigned SCLK_HALF      = 2,
    parameter int unsigned CS_HIGH_CYCLES = 14
) (
    input  logic        dataclk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] mosi_cmd,
    input  logic        MISO,
    output logic [5:0]  channel,
    output logic        CS_b,
    output logic        SCLK,
    output logic        MOSI,
    output logic [15:0] miso_word,
    output logic [5:0]  word_channel,
    output logic        word_valid,
    output logic        frame_done,
    output logic [31:0] timestamp,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StShift, StCsHold, StCsHigh} state_e;

    localparam int unsigned TICK_W = $clog2(2 * SCLK_HALF + 1);
    localparam int unsigned HOLD_W = $clog2(CS_HIGH_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(2 * SCLK_HALF - 1);
    localparam logic [TICK_W-1:0] TICK_HIGH = TICK_W'(SCLK_HALF);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HIGH_CYCLES - 1);
    localparam logic [5:0]        LAST_SLOT = 6'(NUM_SLOTS - 1);

    state_e              state_q, state_d;
    logic                setup_q, setup_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [15:0]         shift_q, shift_d;
    logic [15:0]         reply_q, reply_d;
    logic [5:0]          channel_q, channel_d;
    logic                cs_b_q, cs_b_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [15:0]         miso_word_q, miso_word_d;
    logic [5:0]          word_channel_q, word_channel_d;
    logic                word_valid_q, word_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [31:0]         timestamp_q, timestamp_d;
    logic                busy_q, busy_d;
    logic                start_slot;
    logic [TICK_W-1:0]   tick_inc;

    always_comb begin
        state_d        = state_q;
        setup_d        = setup_q;
        tick_d         = tick_q;
        bit_d          = bit_q;
        hold_d         = hold_q;
        shift_d        = shift_q;
        reply_d        = reply_q;
        channel_d      = channel_q;
        cs_b_d         = 1'b1;
        sclk_d         = 1'b0;
        mosi_d         = 1'b0;
        miso_word_d    = miso_word_q;
        word_channel_d = word_channel_q;
        word_valid_d   = 1'b0;
        frame_done_d   = 1'b0;
        timestamp_d    = timestamp_q;
        start_slot     = 1'b0;
        tick_inc       = tick_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    start_slot = 1'b1;
                end
            end
            StShift: begin
                cs_b_d = 1'b0;
                if (setup_q) begin
                    // Setup cycle done; enter bit 0 with SCLK low.
                    setup_d = 1'b0;
                    tick_d  = '0;
                    mosi_d  = shift_q[15];
                end else if (tick_q == TICK_LAST) begin
                    // Last SCLK-high cycle of the bit: sample the reply.
                    reply_d = {reply_q[14:0], MISO};
                    if (bit_q == 4'd15) begin
                        state_d = StCsHold;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tick_d  = '0;
                        shift_d = {shift_q[14:0], 1'b0};
                        mosi_d  = shift_q[14];
                    end
                end else begin
                    tick_d = tick_inc;
                    sclk_d = (tick_inc >= TICK_HIGH);
                    mosi_d = shift_q[15];
                end
            end
            StCsHold: begin
                state_d        = StCsHigh;
                hold_d         = '0;
                word_valid_d   = 1'b1;
                miso_word_d    = reply_q;
                word_channel_d = channel_q;
                if (channel_q == LAST_SLOT) begin
                    channel_d    = '0;
                    frame_done_d = 1'b1;
                    timestamp_d  = timestamp_q + 32'd1;
                end else begin
                    channel_d = channel_q + 6'd1;
                end
            end
            StCsHigh: begin
                if (hold_q == HOLD_LAST) begin
                    // channel reads 0 here only when this slot closed a frame.
                    if ((channel_q == 6'd0) && !run) begin
                        state_d = StIdle;
                    end else begin
                        start_slot = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_slot) begin
            state_d = StShift;
            setup_d = 1'b1;
            bit_d   = '0;
            tick_d  = '0;
            shift_d = mosi_cmd;
            cs_b_d  = 1'b0;
            mosi_d  = mosi_cmd[15];
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            setup_q        <= 1'b0;
            tick_q         <= '0;
            bit_q          <= '0;
            hold_q         <= '0;
            shift_q        <= '0;
            reply_q        <= '0;
            channel_q      <= '0;
            cs_b_q         <= 1'b1;
            sclk_q         <= 1'b0;
            mosi_q         <= 1'b0;
            miso_word_q    <= '0;
            word_channel_q <= '0;
            word_valid_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            timestamp_q    <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            setup_q        <= setup_d;
            tick_q         <= tick_d;
            bit_q          <= bit_d;
            hold_q         <= hold_d;
            shift_q        <= shift_d;
            reply_q        <= reply_d;
            channel_q      <= channel_d;
            cs_b_q         <= cs_b_d;
            sclk_q         <= sclk_d;
            mosi_q         <= mosi_d;
            miso_word_q    <= miso_word_d;
            word_channel_q <= word_channel_d;
            word_valid_q   <= word_valid_d;
            frame_done_q   <= frame_done_d;
            timestamp_q    <= timestamp_d;
            busy_q         <= busy_d;
        end
    end

    assign channel      = channel_q;
    assign CS_b         = cs_b_q;
    assign SCLK         = sclk_q;
    assign MOSI         = mosi_q;
    assign miso_word    = miso_word_q;
    assign word_channel = word_channel_q;
    assign word_valid   = word_valid_q;
    assign frame_done   = frame_done_q;
    assign timestamp    = timestamp_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rhd_spi_slot_sequencer.sv
// Bench for rhd_spi_slot_sequencer: a default instance and a minimal-parameter
// instance, each compared every cycle against a slot-position model, plus
// directed literal expectations.
module tb_rhd_spi_slot_sequencer;

    localparam int N0 = 35;
    localparam int H0 = 2;
    localparam int C0 = 14;

    typedef struct packed {
        logic        running;
        int          pos;
        logic [5:0]  ch;
        logic [15:0] s;
        logic [15:0] rep;
        logic [15:0] word;
        logic [5:0]  wch;
        logic        wv;
        logic        fd;
        logic        wrapped;
        logic [31:0] ts;
    } model_t;

    logic dataclk = 1'b0;
    always #5 dataclk = ~dataclk;
    logic reset_n = 1'b1;

    // Default instance
    logic        run = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] cmd_fixed = 16'hA5C3;
    logic [15:0] mosi_cmd;
    logic        miso_in;
    logic [5:0]  channel, word_channel;
    logic        CS_b, SCLK, mosi_out, word_valid, frame_done, busy;
    logic [15:0] miso_word;
    logic [31:0] timestamp;

    // Minimal-parameter instance, MISO looped back to MOSI
    logic        run_c = 1'b0;
    logic [15:0] cmd_c = 16'h3C5A;
    logic [5:0]  channel_c, word_channel_c;
    logic        cs_b_c, sclk_c, mosi_c, word_valid_c, frame_done_c, busy_c;
    logic [15:0] miso_word_c;
    logic [31:0] timestamp_c;

    logic digout_override = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;
    logic mon_en = 1'b0;

    // Stand-in for the command selector: CONVERT(ch) for 0..31, aux command at 32.
    function automatic logic [15:0] cmd_sel(logic [5:0] ch);
        logic [15:0] aux;
        aux = 16'h8301;
        aux[0] = digout_override;
        if (ch < 6'd32) return {2'b00, ch, 8'h00};
        if (ch == 6'd32) return aux;
        return {2'b11, ch, 8'h5A};
    endfunction

    always_comb begin
        mosi_cmd = cmd_fixed;
        miso_in  = ~mosi_out;
        if (mode) begin
            mosi_cmd = cmd_sel(channel);
            miso_in  = mosi_out;
        end
    end

    rhd_spi_slot_sequencer #(
        .NUM_SLOTS(N0), .SCLK_HALF(H0), .CS_HIGH_CYCLES(C0)
    ) dut (
        .dataclk(dataclk), .reset_n(reset_n), .run(run), .mosi_cmd(mosi_cmd),
        .MISO(miso_in), .channel(channel), .CS_b(CS_b), .SCLK(SCLK), .MOSI(mosi_out),
        .miso_word(miso_word), .word_channel(word_channel), .word_valid(word_valid),
        .frame_done(frame_done), .timestamp(timestamp), .busy(busy)
    );

    rhd_spi_slot_sequencer #(
        .NUM_SLOTS(1), .SCLK_HALF(1), .CS_HIGH_CYCLES(2)
    ) dut_c (
        .dataclk(dataclk), .reset_n(reset_n), .run(run_c), .mosi_cmd(cmd_c),
        .MISO(mosi_c), .channel(channel_c), .CS_b(cs_b_c), .SCLK(sclk_c), .MOSI(mosi_c),
        .miso_word(miso_word_c), .word_channel(word_channel_c), .word_valid(word_valid_c),
        .frame_done(frame_done_c), .timestamp(timestamp_c), .busy(busy_c)
    );

    // Model: the slot is described by its cycle position; outputs follow from it.
    function automatic model_t model_edge(model_t m, logic run_v, logic [15:0] cmd,
                                          logic miso, int n, int h, int csh);
        model_t r;
        int len;
        r = m;
        len = 2 + 32 * h + csh;
        r.wv = 1'b0;
        r.fd = 1'b0;
        if (!m.running) begin
            if (run_v) begin
                r.running = 1'b1;
                r.pos = 0;
                r.s = cmd;
            end
            return r;
        end
        if (m.pos >= 1 && m.pos <= 32 * h && (m.pos % (2 * h)) == 0)
            r.rep = {m.rep[14:0], miso};
        if (m.pos == len - 1) begin
            if (m.wrapped && !run_v) begin
                r.running = 1'b0;
            end else begin
                r.pos = 0;
                r.s = cmd;
            end
        end else begin
            r.pos = m.pos + 1;
        end
        if (r.running && r.pos == 32 * h + 2) begin
            r.wv = 1'b1;
            r.word = r.rep;
            r.wch = m.ch;
            if (int'(m.ch) + 1 == n) r.ch = 6'd0;
            else r.ch = m.ch + 6'd1;
            r.wrapped = (int'(m.ch) + 1 == n);
            if (r.wrapped) begin
                r.fd = 1'b1;
                r.ts = m.ts + 32'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [65:0] exp_out(model_t m, int h);
        logic cs_b, sclk, mosi;
        int p;
        cs_b = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        p = m.pos;
        if (m.running) begin
            if (p <= 32 * h + 1) cs_b = 1'b0;
            if (p == 0) begin
                mosi = m.s[15];
            end else if (p <= 32 * h) begin
                mosi = m.s[15 - (p - 1) / (2 * h)];
                sclk = ((p - 1) % (2 * h)) >= h;
            end
        end
        return {m.ch, cs_b, sclk, mosi, m.word, m.wch, m.wv, m.fd, m.ts, m.running};
    endfunction

    model_t m = '0;
    model_t mc = '0;
    logic        s_run = 1'b0, s_miso = 1'b0, s_run_c = 1'b0, s_miso_c = 1'b0;
    logic [15:0] s_cmd = '0, s_cmd_c = '0;

    always @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            m  <= '0;
            mc <= '0;
        end else begin
            m  <= model_edge(m, s_run, s_cmd, s_miso, N0, H0, C0);
            mc <= model_edge(mc, s_run_c, s_cmd_c, s_miso_c, 1, 1, 2);
        end
    end

    always @(posedge dataclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    // Sample inputs for the model's next edge and compare outputs every cycle.
    always @(negedge dataclk) begin
        s_run    <= run;
        s_cmd    <= mosi_cmd;
        s_miso   <= miso_in;
        s_run_c  <= run_c;
        s_cmd_c  <= cmd_c;
        s_miso_c <= mosi_c;
        if (chk_en) begin
            check_vec("cycle_cmp", {channel, CS_b, SCLK, mosi_out, miso_word, word_channel,
                      word_valid, frame_done, timestamp, busy}, exp_out(m, H0));
            check_vec("cycle_cmp_corner", {channel_c, cs_b_c, sclk_c, mosi_c, miso_word_c,
                      word_channel_c, word_valid_c, frame_done_c, timestamp_c, busy_c},
                      exp_out(mc, 1));
        end
    end

    int          wv_q[$];
    int          fd_cyc[$];
    logic [31:0] fd_ts[$];
    logic [5:0]  fd_wch[$];
    logic [15:0] words [64];

    always @(negedge dataclk) begin
        if (mon_en) begin
            if (word_valid) begin
                wv_q.push_back(cyc);
                words[word_channel] <= miso_word;
            end
            if (frame_done) begin
                fd_cyc.push_back(cyc);
                fd_ts.push_back(timestamp);
                fd_wch.push_back(word_channel);
            end
        end
    end

    task automatic tick();
        @(posedge dataclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_low, cs_high, n_rise, first_rise, wv_i, bad, n_fd;
        logic prev_sclk, found;
        logic [15:0] bits, wv_word;
        int c_wv, c_first, c_last, c_per_bad, c_fd_bad, c_chan_bad;

        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_cs_b", 32'(CS_b), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timestamp", timestamp, 32'd0);
        reset_n = 1'b1;
        repeat (5) tick();
        check("idle_no_run_busy", 32'(busy), 32'd0);
        check("idle_no_run_cs_b", 32'(CS_b), 32'd1);

        // Single-slot waveform with a fixed command; MISO returns ~MOSI.
        run = 1'b1;
        cs_low = 0; cs_high = 0; n_rise = 0; first_rise = -1; wv_i = -1;
        prev_sclk = 1'b0; bits = '0; wv_word = '0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (!CS_b) cs_low++;
            else cs_high++;
            if (SCLK && !prev_sclk) begin
                if (n_rise == 0) first_rise = i;
                n_rise++;
                bits = {bits[14:0], mosi_out};
            end
            prev_sclk = SCLK;
            if (word_valid) begin
                wv_i = i;
                wv_word = miso_word;
                check("model_word_slot0", 32'(m.word), 32'h5A3C);
            end
        end
        check("slot0_cs_low_cycles", 32'(cs_low), 32'd66);
        check("slot0_cs_high_cycles", 32'(cs_high), 32'd14);
        check("slot0_sclk_rises", 32'(n_rise), 32'd16);
        check("slot0_first_rise", 32'(first_rise), 32'd3);
        check("slot0_mosi_bits", 32'(bits), 32'hA5C3);
        check("slot0_wv_cycle", 32'(wv_i), 32'd66);
        check("slot0_reply", 32'(wv_word), 32'h5A3C);

        // Reset in the middle of slot 1, bit 7.
        repeat (31) tick();
        check("pre_rst_cs_b", 32'(CS_b), 32'd0);
        check("pre_rst_channel", 32'(channel), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_cs_b", 32'(CS_b), 32'd1);
        check("midrst_sclk", 32'(SCLK), 32'd0);
        check("midrst_mosi", 32'(mosi_out), 32'd0);
        check("midrst_channel", 32'(channel), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_word_valid", 32'(word_valid), 32'd0);
        run = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("post_rst_idle", 32'({busy, CS_b}), 32'b01);

        // Continuous frames with selector and loopback; stop requested in frame 4.
        mode = 1'b1;
        mon_en = 1'b1;
        run = 1'b1;
        n_fd = 0;
        for (int c = 0; c < 3 * 2800 + 200 && n_fd < 3; c++) begin
            tick();
            if (frame_done) n_fd++;
        end
        check("three_frames", 32'(n_fd), 32'd3);
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            tick();
            if (channel == 6'd10) found = 1'b1;
        end
        check("reach_slot10", 32'(found), 32'd1);
        run = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            tick();
            if (frame_done) found = 1'b1;
        end
        check("frame4_completes", 32'(found), 32'd1);
        repeat (13) tick();
        check("busy_last_cs_high", 32'(busy), 32'd1);
        tick();
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_channel", 32'(channel), 32'd0);
        check("stop_cs_b", 32'(CS_b), 32'd1);
        check("stop_timestamp", timestamp, 32'd4);
        check("model_stop_ts", m.ts, 32'd4);
        mon_en = 1'b0;

        check("wv_count", 32'(wv_q.size()), 32'd140);
        bad = 0;
        for (int i = 1; i < wv_q.size(); i++) if (wv_q[i] - wv_q[i-1] != 80) bad++;
        check("wv_period_bad", 32'(bad), 32'd0);
        check("fd_count", 32'(fd_cyc.size()), 32'd4);
        for (int i = 0; i < fd_ts.size(); i++) begin
            check("fd_timestamp", fd_ts[i], 32'(i + 1));
            check("fd_word_channel", 32'(fd_wch[i]), 32'd34);
        end
        for (int i = 1; i < fd_cyc.size(); i++)
            check("fd_period", 32'(fd_cyc[i] - fd_cyc[i-1]), 32'd2800);
        check("loopback_slot5", 32'(words[5]), 32'h0500);
        check("loopback_slot32", 32'(words[32]), 32'h8300);

        // Restart: slot 0 on the next edge, timestamp carries on.
        run = 1'b1;
        tick();
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_cs_b", 32'(CS_b), 32'd0);
        check("restart_channel", 32'(channel), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (word_valid) found = 1'b1;
        end
        check("restart_wv_seen", 32'(found), 32'd1);
        check("restart_word_channel", 32'(word_channel), 32'd0);
        check("restart_timestamp", timestamp, 32'd4);
        found = 1'b0;
        for (int c = 0; c < 2900 && !found; c++) begin
            tick();
            if (frame_done) found = 1'b1;
        end
        check("restart_frame_done", 32'(found), 32'd1);
        check("restart_ts_next", timestamp, 32'd5);
        run = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (!busy) found = 1'b1;
        end
        check("restart_stop_idle", 32'(found), 32'd1);

        // Minimal-parameter instance: 36-cycle slots, every slot ends a frame.
        c_wv = 0; c_first = -1; c_last = 0; c_per_bad = 0; c_fd_bad = 0; c_chan_bad = 0;
        run_c = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            tick();
            if (channel_c != 6'd0) c_chan_bad++;
            if (word_valid_c != frame_done_c) c_fd_bad++;
            if (word_valid_c) begin
                if (c_wv == 0) c_first = j;
                else if (j - c_last != 36) c_per_bad++;
                c_wv++;
                c_last = j;
            end
        end
        check("corner_wv_count", 32'(c_wv), 32'd11);
        check("corner_first_wv", 32'(c_first), 32'd35);
        check("corner_period_bad", 32'(c_per_bad), 32'd0);
        check("corner_fd_with_wv_bad", 32'(c_fd_bad), 32'd0);
        check("corner_channel_bad", 32'(c_chan_bad), 32'd0);
        check("corner_timestamp", timestamp_c, 32'd11);
        check("corner_reply", 32'(miso_word_c), 32'h3C5A);
        run_c = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            if (!busy_c) found = 1'b1;
        end
        check("corner_stop_idle", 32'(found), 32'd1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rhd_spi_slot_sequencer.md
Name: rhd_spi_slot_sequencer

Overview:
- Frame engine for one RHD-style amplifier SPI port.
- Steps a 6-bit slot index 0..NUM_SLOTS-1, which drives the downstream MOSI command selector.
- Latches the 16-bit command that selector returns and shifts it out MSB-first on SCLK/MOSI under CS_b, while capturing the 16-bit MISO reply.
- Presents each reply word with its slot index to the data-capture stage, and marks frame boundaries with a pulse and a frame timestamp.

Parameters:
- NUM_SLOTS, 35, slots per frame. Legal range 1..64.
- SCLK_HALF, 2, dataclk cycles per SCLK half-period. Must be >=1.
- CS_HIGH_CYCLES, 14, dataclk cycles CS_b is held high between slots. Must be >=2.

Ports:
- dataclk  in  1  block clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = start and keep framing; 0 = stop at the next frame boundary
- mosi_cmd  in  16  command word for the current slot index, from the command selector
- MISO  in  1  serial data from the amplifier
- channel  out  6  current slot index, to the command selector
- CS_b  out  1  active-low chip select
- SCLK  out  1  SPI clock, idle low
- MOSI  out  1  serial command data
- miso_word  out  16  last captured reply
- word_channel  out  6  slot index of miso_word
- word_valid  out  1  one-cycle pulse when miso_word/word_channel update
- frame_done  out  1  one-cycle pulse with word_valid of the last slot
- timestamp  out  32  completed-frame count
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0): state=IDLE, channel=0, CS_b=1, SCLK=0, MOSI=0, miso_word=0, word_channel=0, word_valid=0, frame_done=0, timestamp=0, busy=0.
- Reset mid-slot aborts immediately; no partial word is emitted.
- States: IDLE, SHIFT, CS_HOLD, CS_HIGH.
- IDLE: channel=0. When run=1 at a clock edge, that edge latches mosi_cmd into shift register S and enters slot cycle 0.
- Slot timing, with H=SCLK_HALF and cycle 0 = first cycle with CS_b=0:
  - Cycle 0 (setup): CS_b=0, SCLK=0, MOSI=S[15].
  - Bit k (k=0..15) occupies cycles 1+2Hk .. 2H(k+1). MOSI=S[15-k] for the whole window; SCLK=0 for the first H cycles and 1 for the last H cycles.
  - MISO is sampled at the dataclk edge that ends bit k's window (last SCLK-high cycle) and shifted into the reply register, MSB first.
  - Cycle 32H+1: CS_HOLD, with CS_b=0, SCLK=0, MOSI=0.
  - Cycles 32H+2 .. 32H+1+CS_HIGH_CYCLES: CS_HIGH, with CS_b=1, SCLK=0, MOSI=0.
- Slot length is 2+32H+CS_HIGH_CYCLES cycles; the defaults give 80.
- On the first CS_HIGH cycle:
  - word_valid=1 for that cycle only.
  - miso_word is set to the captured reply; word_channel is set to the finishing slot.
  - channel advances to slot+1, wrapping to 0 after NUM_SLOTS-1.
- On wrap:
  - frame_done=1 in the same cycle as word_valid.
  - timestamp increments, wrapping at 2^32.
- Last CS_HIGH cycle: the edge ending it latches mosi_cmd (now for the new channel) into S and starts the next slot's cycle 0.
- Exception: if the wrap has just occurred and run=0 during that last cycle, the block goes to IDLE instead. CS_b stays 1, channel stays 0, busy drops.
- run=0 mid-frame has no effect until the frame boundary; the frame always completes. run toggling at any other time is ignored.
- Re-asserting run in IDLE restarts at slot 0. timestamp is not cleared by a stop/start.
- Default frame: 35 slots x 80 cycles = 2800 dataclk cycles.

Test Plan:
- Reset values: assert reset_n=0 mid-bit (slot cycle 30) -> in the same cycle CS_b=1, SCLK=0, MOSI=0, channel=0, busy=0, no word_valid. After release with run=0 the block stays IDLE.
- Single-slot waveform, defaults, mosi_cmd held 16'hA5C3, run=1 for one frame:
  - Slot 0 shows CS_b low for exactly 66 cycles and 16 SCLK rising edges, the first at slot cycle 3.
  - MOSI bits read 1010_0101_1100_0011 at each rising edge.
  - CS_b is high for 14 cycles.
- Loopback: MISO tied to MOSI, command selector in the loop -> for slot 5 miso_word=16'h0500 (DSP_settle=0) with word_channel=5. For slot 32 with aux 16'h8301 and digout_override=0, miso_word=16'h8300.
- Frame sequencing, run=1 continuously for 3 frames:
  - channel steps 0..34.
  - word_valid every 80 cycles.
  - frame_done every 2800 cycles, coincident with word_channel=34.
  - timestamp reads 1, 2, 3.
- Stop mid-frame: drop run at slot 10 -> slots 11..34 still run, then IDLE with busy=0 and channel=0 exactly 14 cycles after the final word_valid. Re-raise run -> slot 0 starts on the next edge and timestamp continues from its prior value.
- Parameter corner: NUM_SLOTS=1, SCLK_HALF=1, CS_HIGH_CYCLES=2 -> slot length 36 cycles, frame_done on every word_valid, channel constant 0.
